// File: rtl/pipelined_array_multiplier_if.sv
// Operand/result handshake bundle for the pipelined array multiplier.
// The producer side drives operands and out_ready; the multiplier drives the rest.
interface pipelined_array_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/pipelined_array_multiplier.sv
// Pipelined WIDTH x WIDTH array multiplier, unsigned or Baugh-Wooley signed per transaction.
// Each stage folds ROWS_PER_STAGE partial-product rows into a registered running sum.
module pipelined_array_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  pipelined_array_multiplier_if.slave  bus
);
  localparam int LATENCY = WIDTH / ROWS_PER_STAGE;
  localparam int PW      = 2 * WIDTH;
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  if (WIDTH < 2 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_param_check
    $error("WIDTH must be >= 2 and a multiple of ROWS_PER_STAGE");
  end

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] sgn_q, sgn_d;
  logic [WIDTH-1:0]   a_q   [LATENCY];
  logic [WIDTH-1:0]   b_q   [LATENCY];
  logic [PW-1:0]      sum_q [LATENCY];
  logic [WIDTH-1:0]   a_d   [LATENCY];
  logic [WIDTH-1:0]   b_d   [LATENCY];
  logic [PW-1:0]      sum_d [LATENCY];
  logic               advance;

  // Row terms that pair an operand MSB with a non-MSB bit are inverted in signed mode.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a, input logic b_bit,
                                           input logic sgn, input int row);
    logic [WIDTH-1:0] bits;
    logic [WIDTH-1:0] flip;
    bits = a & {WIDTH{b_bit}};
    if (row == WIDTH - 1) flip = {1'b0, {(WIDTH-1){1'b1}}};
    else                  flip = {1'b1, {(WIDTH-1){1'b0}}};
    if (sgn) bits = bits ^ flip;
    return PW'(bits) << row;
  endfunction

  always_comb begin
    logic [WIDTH-1:0] b_shift;
    b_shift = '0;
    for (int k = 0; k < LATENCY; k++) begin
      if (k == 0) begin
        valid_d[k] = bus.in_valid;
        sgn_d[k]   = bus.in_signed;
        a_d[k]     = bus.in_a;
        b_d[k]     = bus.in_b;
        sum_d[k]   = bus.in_signed ? BW_CONST : '0;
      end else begin
        valid_d[k] = valid_q[k-1];
        sgn_d[k]   = sgn_q[k-1];
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        sum_d[k]   = sum_q[k-1];
      end
      for (int r = 0; r < ROWS_PER_STAGE; r++) begin
        b_shift  = b_d[k] >> (k * ROWS_PER_STAGE + r);
        sum_d[k] = sum_d[k] + pp_row(a_d[k], b_shift[0], sgn_d[k], k * ROWS_PER_STAGE + r);
      end
    end
  end

  // Whole pipe moves together; stalled bubbles stay where they are.
  assign advance = ~valid_q[LATENCY-1] | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sgn_q   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      sgn_q   <= sgn_d;
      for (int k = 0; k < LATENCY; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign bus.in_ready    = advance;
  assign bus.out_valid   = valid_q[LATENCY-1];
  assign bus.out_product = sum_q[LATENCY-1];
  assign bus.busy        = |valid_q;
endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Bench for pipelined_array_multiplier: queue-based delay-line model with plain integer products,
// main 8x8 instance plus a parameter sweep (4/1, 4/4, 16/4).
module tb_pipelined_array_multiplier;
  localparam int W   = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic        v;
    logic        k;
    logic [63:0] p;
  } slot_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   probe_cyc = 0;
  logic [63:0] probe_exp = '0;
  bit   probe_on = 0;
  bit   pinned = 0;
  bit   sweep_go = 0;
  bit   timeout = 0;
  slot_t mq[$];
  slot_t o_exp;
  bit    busy_exp;

  logic [66:0] sw_exp [3];
  logic [66:0] sw_act [3];
  logic        sw_or  [3];
  logic        sw_done[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_array_multiplier_if #(.WIDTH(W)) mif ();
  pipelined_array_multiplier #(.WIDTH(W), .ROWS_PER_STAGE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(mif.slave));

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int w);
    longint x, y;
    logic [63:0] mask;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(x * y) & mask;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Main model: a LAT-deep delay line that only moves when the output is free or taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      repeat (LAT) mq.push_back(slot_t'{v:1'b0, k:1'b1, p:64'd0});
    end else begin
      cyc++;
      if (mq.size() == LAT && (!mq[LAT-1].v || mif.out_ready)) begin
        void'(mq.pop_back());
        if (mif.in_valid)
          mq.push_front(slot_t'{v:1'b1, k:1'b1,
                                p:ref_mul(64'(mif.in_a), 64'(mif.in_b), mif.in_signed, W)});
        else
          mq.push_front(slot_t'{v:1'b0, k:1'b0, p:64'd0});
      end
    end
  end

  always @(negedge clk) begin
    if (!pinned) begin
      chk("pin_ff_ff_u", ref_mul(64'hFF, 64'hFF, 1'b0, 8), 64'hFE01);
      chk("pin_f8_07_u", ref_mul(64'hF8, 64'h07, 1'b0, 8), 64'h06C8);
      chk("pin_f8_07_s", ref_mul(64'hF8, 64'h07, 1'b1, 8), 64'hFFC8);
      chk("pin_80_80_s", ref_mul(64'h80, 64'h80, 1'b1, 8), 64'h4000);
      chk("pin_00_a5_s", ref_mul(64'h00, 64'hA5, 1'b1, 8), 64'h0000);
      chk("pin_w4_8_7_s", ref_mul(64'h8, 64'h7, 1'b1, 4), 64'hC8);
      pinned = 1;
    end
    if (mq.size() == LAT) begin
      o_exp = mq[LAT-1];
      busy_exp = 0;
      foreach (mq[i]) busy_exp = busy_exp | mq[i].v;
      chk("out_valid", 64'(mif.out_valid), 64'(o_exp.v));
      chk("busy", 64'(mif.busy), 64'(busy_exp));
      chk("in_ready", 64'(mif.in_ready), 64'(!o_exp.v || mif.out_ready));
      if (o_exp.k) chk("out_product", 64'(mif.out_product), o_exp.p);
    end
    if (probe_on && mif.out_valid) begin
      chk("corner_latency", 64'(cyc - probe_cyc), 64'(LAT - 1));
      chk("corner_product", 64'(mif.out_product), probe_exp);
    end
    if (timeout)
      chk("sweep_done", 64'({sw_done[2], sw_done[1], sw_done[0]}), 64'd7);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("sw%0d_out_valid", g), 64'(sw_act[g][66]), 64'(sw_exp[g][66]));
      chk($sformatf("sw%0d_busy", g), 64'(sw_act[g][65]), 64'(sw_exp[g][64]));
      chk($sformatf("sw%0d_in_ready", g), 64'(sw_act[g][64]),
          64'(!sw_exp[g][66] || sw_or[g]));
      if (sw_exp[g][65])
        chk($sformatf("sw%0d_out_product", g), sw_act[g][63:0], sw_exp[g][63:0]);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 2) ? 16 : 4;
    localparam int SR = (g == 0) ? 1 : 4;
    localparam int SL = SW / SR;
    localparam int NV = (g == 2) ? 300 : 512;

    pipelined_array_multiplier_if #(.WIDTH(SW)) sif ();
    pipelined_array_multiplier #(.WIDTH(SW), .ROWS_PER_STAGE(SR)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(sif.slave));

    slot_t       sq[$];
    logic        e_v = 1'b0;
    logic        e_k = 1'b1;
    logic        e_busy = 1'b0;
    logic [63:0] e_p = '0;
    bit          done = 0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sq.delete();
        repeat (SL) sq.push_back(slot_t'{v:1'b0, k:1'b1, p:64'd0});
      end else if (sq.size() == SL && (!sq[SL-1].v || sif.out_ready)) begin
        void'(sq.pop_back());
        if (sif.in_valid)
          sq.push_front(slot_t'{v:1'b1, k:1'b1,
                                p:ref_mul(64'(sif.in_a), 64'(sif.in_b), sif.in_signed, SW)});
        else
          sq.push_front(slot_t'{v:1'b0, k:1'b0, p:64'd0});
      end
      if (sq.size() == SL) begin
        e_v = sq[SL-1].v;
        e_k = sq[SL-1].k;
        e_p = sq[SL-1].p;
        e_busy = 0;
        foreach (sq[i]) e_busy = e_busy | sq[i].v;
      end
    end

    assign sw_exp[g]  = {e_v, e_k, e_busy, e_p};
    assign sw_act[g]  = {sif.out_valid, sif.busy, sif.in_ready, 64'(sif.out_product)};
    assign sw_or[g]   = sif.out_ready;
    assign sw_done[g] = done;

    // Exhaustive at WIDTH=4 (index bit 8 selects signed), random at WIDTH=16.
    initial begin
      int idx;
      bit took;
      idx = 0;
      took = 0;
      sif.in_valid = 1'b0;
      sif.in_a = '0;
      sif.in_b = '0;
      sif.in_signed = 1'b0;
      sif.out_ready = 1'b1;
      wait (sweep_go);
      while (idx < NV) begin
        @(posedge clk);
        #1;
        if (took) idx++;
        if (idx < NV) begin
          sif.in_valid = 1'b1;
          if (SW == 4) begin
            sif.in_a = SW'(idx % 16);
            sif.in_b = SW'((idx / 16) % 16);
            sif.in_signed = (idx >= 256);
          end else begin
            sif.in_a = SW'($urandom);
            sif.in_b = SW'($urandom);
            sif.in_signed = 1'($urandom);
          end
        end else begin
          sif.in_valid = 1'b0;
        end
        sif.out_ready = ($urandom_range(0, 3) != 0);
        #1 took = sif.in_valid && sif.in_ready;
      end
      sif.out_ready = 1'b1;
      repeat (SL + 3) @(posedge clk);
      done = 1;
    end
  end

  task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input bit s, input bit ordy);
    @(posedge clk);
    #1;
    mif.in_valid  = v;
    mif.in_a      = a;
    mif.in_b      = b;
    mif.in_signed = s;
    mif.out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic corner(input logic [7:0] a, input logic [7:0] b, input bit s,
                        input logic [15:0] exp);
    @(posedge clk);
    #1;
    mif.in_valid  = 1'b1;
    mif.in_a      = a;
    mif.in_b      = b;
    mif.in_signed = s;
    mif.out_ready = 1'b1;
    probe_cyc = cyc + 1;
    probe_exp = 64'(exp);
    probe_on  = 1;
    @(posedge clk);
    #1 mif.in_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1 probe_on = 0;
  endtask

  initial begin
    bit [6:0] pat;
    pat = 7'b1011001;
    rst_n = 1'b0;
    mif.in_valid = 1'b0;
    mif.in_a = '0;
    mif.in_b = '0;
    mif.in_signed = 1'b0;
    mif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    corner(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    corner(8'hF8, 8'h07, 1'b0, 16'h06C8);
    corner(8'hF8, 8'h07, 1'b1, 16'hFFC8);
    corner(8'h80, 8'h80, 1'b1, 16'h4000);
    corner(8'h00, 8'hA5, 1'b1, 16'h0000);

    for (int i = 0; i < 256; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    idle(LAT + 2);

    for (int i = 0; i < 20; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), !(i >= 8 && i < 13));
    idle(LAT + 2);

    for (int i = 6; i >= 0; i--)
      drive(pat[i], 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    idle(LAT + 4);

    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(LAT + 4);

    for (int i = 0; i < 300; i++)
      drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    idle(LAT + 4);

    sweep_go = 1;
    for (int i = 0; i < 20000 && !(sw_done[0] && sw_done[1] && sw_done[2]); i++)
      @(posedge clk);
    if (!(sw_done[0] && sw_done[1] && sw_done[2])) timeout = 1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
